ulactrl_multiciclo: RTL
=======================

Name: ulactrl_multiciclo

Overview:
- Multicycle control unit: the producer of ULAcontrol and the consumer of Z for the 32-bit ULA in the multicycle MIPS-subset datapath.
- Moore FSM sequences fetch/decode/execute/memory/writeback for the instructions lw, sw, R-type (add, sub, and, or, slt), beq, addi and j.
- Drives every datapath enable and mux select, plus the ULA operation code.
- Any undefined opcode/funct traps into a halt state with an error flag raised.

Parameters:
- NSTATE_W, 4, width of state encoding and of the Estado debug port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Op  in  6  instruction bits [31:26] from instruction register.
- Funct  in  6  instruction bits [5:0] from instruction register.
- Z  in  1  ULA zero flag (ULAresult == 0).
- ULAcontrol  out  3  ULA operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ULASrcA  out  1  0=PC, 1=register A.
- ULASrcB  out  2  00=B, 01=constant 4, 10=SignImm, 11=SignImm<<2.
- IorD  out  1  memory address select: 0=PC, 1=ULAOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  0=rt, 1=rd.
- MemtoReg  out  1  0=ULAOut, 1=Data.
- RegWrite  out  1  register file write enable.
- PCSrc  out  2  00=ULAresult, 01=ULAOut, 10=jump target.
- PCEn  out  1  PC load = PCWrite | (Branch & Z).
- Erro  out  1  sticky illegal-instruction flag.
- Estado  out  NSTATE_W  current state, for debug.

Behaviour:
- Clock and reset:
  - Single clock, one state transition per rising edge.
  - rst_n low asynchronously forces state FETCH and clears Erro.
  - While rst_n is low, all write/load enables are forced to 0: MemWrite, IRWrite, RegWrite, PCEn.
  - Other outputs take their FETCH values. Estado = 0.
- Outputs are decoded combinationally from state (Moore). Exceptions: ULAcontrol in EXECUTE also depends on Funct, and PCEn in BRANCH also depends on Z.
- Unlisted outputs are 0 in each state.
- States, with outputs and next state:
  - FETCH(0): IorD=0, IRWrite=1, ULASrcA=0, ULASrcB=01, ULAcontrol=000, PCSrc=00, PCWrite=1. Next: DECODE.
  - DECODE(1): ULASrcA=0, ULASrcB=11, ULAcontrol=000 (branch target into ULAOut). Next by Op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEXEC
    - 000010 -> JUMP
    - other -> ERRO
  - MEMADR(2): ULASrcA=1, ULASrcB=10, ULAcontrol=000. Next: Op=100011 -> MEMREAD, else MEMWRITE.
  - MEMREAD(3): IorD=1. Next: MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWRITE(5): IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE(6): ULASrcA=1, ULASrcB=00. ULAcontrol by Funct:
    - 100000 -> 000
    - 100010 -> 001
    - 100100 -> 010
    - 100101 -> 011
    - 101010 -> 101
    - Next: ULAWB. Any other Funct -> ERRO, with ULAcontrol=000 and no write.
  - ULAWB(7): RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH(8): ULASrcA=1, ULASrcB=00, ULAcontrol=001, PCSrc=01, Branch=1, so PCEn=Z. Next: FETCH.
  - ADDIEXEC(9): ULASrcA=1, ULASrcB=10, ULAcontrol=000. Next: ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - JUMP(11): PCSrc=10, PCWrite=1. Next: FETCH.
  - ERRO(15): all enables 0, Erro=1. Stays in ERRO until rst_n.
  - Unused encodings 12-14 -> ERRO on the next edge.
- Instruction latencies (cycles, FETCH through the last state):
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
- ULAcontrol is never X or an unlisted encoding; the codes 100, 110 and 111 are never driven.
- Op/Funct are sampled only in DECODE/EXECUTE; changes in other states have no effect.
- Reset asserted mid-instruction: no partial write completes after the asynchronous assertion. On release, the first edge performs the FETCH action.

Decomposition:
- Package ulactrl_pkg holds:
  - the state enum typedef (4-bit);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - ULA op constants ULA_ADD, ULA_SUB, ULA_AND, ULA_OR, ULA_SLT.
- The ULA must also import these ULA op constants.
- One sub-module is natural: ula_decoder, a combinational map of (ULAOp[1:0] from the FSM, Funct) to ULAcontrol plus a funct-illegal flag.
  - ULAOp 00 -> add
  - ULAOp 01 -> sub
  - ULAOp 10 -> funct-decoded

Test Plan:
- Reset: hold rst_n=0, then release. Required: Estado=0, all enables 0 during reset. First edge after release: IRWrite=1, PCEn=1, ULASrcB=01, ULAcontrol=000.
- lw (Op=100011): Estado sequence 0,1,2,3,4,0. In state 4: RegWrite=1, MemtoReg=1. In state 3: IorD=1. MemWrite never 1.
- R-type sub then slt (Op=0, Funct=100010, then 101010): in EXECUTE, ULAcontrol=001 then 101. In ULAWB: RegDst=1, RegWrite=1. 4 cycles each.
- beq with Z=1 vs Z=0: in state 8, PCEn=1 with PCSrc=01 when Z=1; PCEn=0 when Z=0. Both return to state 0 next cycle.
- Illegal Op=111111 in DECODE -> Estado=15, Erro=1, all enables 0 for 10+ cycles. rst_n pulse -> Erro=0, Estado=0. Same check for Funct=000111 in EXECUTE.
- Asynchronous reset asserted mid-cycle in MEMWRITE: MemWrite drops to 0 immediately, without waiting for a clock edge. Estado=0 after release.

Source files
------------

// File: rtl/ulactrl_pkg.sv
// ---------------------------------------------------------------------------
// ulactrl_pkg
// Shared definitions for the multicycle control unit and its ULA decoder:
//   - state_e   : FSM state encoding (4 bit; 12..14 unused, 15 = trap)
//   - OP_*      : instruction opcodes (IR[31:26])
//   - F_*       : R-type funct codes (IR[5:0])
//   - ULA_*     : ULA operation codes driven on ULAcontrol
//   - ULAOP_*   : FSM-to-decoder operation class
// ---------------------------------------------------------------------------
package ulactrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ULAWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_ERRO     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b101;

  localparam logic [1:0] ULAOP_ADD   = 2'b00;
  localparam logic [1:0] ULAOP_SUB   = 2'b01;
  localparam logic [1:0] ULAOP_FUNCT = 2'b10;

endpackage

// File: rtl/ulactrl_multiciclo_ula_decoder.sv
// ---------------------------------------------------------------------------
// ula_decoder
// Combinational map from the FSM operation class and the R-type funct field
// to the 3-bit ULA operation code.
//   ula_op_i        : 00 add, 01 sub, 10 decode funct (11 treated as add)
//   funct_i         : instruction bits [5:0]
//   ula_control_o   : ULA operation code (only 000/001/010/011/101 ever driven)
//   funct_illegal_o : 1 when ula_op_i=10 and funct_i is not a supported code
// ---------------------------------------------------------------------------
module ula_decoder
  import ulactrl_pkg::*;
(
  input  logic [1:0] ula_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] ula_control_o,
  output logic       funct_illegal_o
);

  always_comb begin
    ula_control_o   = ULA_ADD;
    funct_illegal_o = 1'b0;
    case (ula_op_i)
      ULAOP_SUB: ula_control_o = ULA_SUB;
      ULAOP_FUNCT: begin
        case (funct_i)
          F_ADD:   ula_control_o = ULA_ADD;
          F_SUB:   ula_control_o = ULA_SUB;
          F_AND:   ula_control_o = ULA_AND;
          F_OR:    ula_control_o = ULA_OR;
          F_SLT:   ula_control_o = ULA_SLT;
          // Unknown funct: keep a harmless add code and flag the trap.
          default: funct_illegal_o = 1'b1;
        endcase
      end
      default: ula_control_o = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/ulactrl_multiciclo.sv
// ---------------------------------------------------------------------------
// ulactrl_multiciclo
// Moore control FSM for the multicycle MIPS-subset datapath (lw, sw, R-type
// add/sub/and/or/slt, beq, addi, j). Illegal opcode/funct traps to S_ERRO,
// which holds until reset and raises the sticky Erro flag.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   Op, Funct           : IR[31:26], IR[5:0]
//   Z                   : ULA zero flag (qualifies PCEn in BRANCH)
//   ULAcontrol          : ULA operation code
//   ULASrcA, ULASrcB    : ULA operand selects
//   IorD                : memory address select
//   MemWrite, IRWrite   : memory write / IR load enables
//   RegDst, MemtoReg    : register file write address/data selects
//   RegWrite            : register file write enable
//   PCSrc, PCEn         : next-PC select and PC load
//   Erro                : sticky illegal-instruction flag
//   Estado              : current state (debug)
// ---------------------------------------------------------------------------
module ulactrl_multiciclo
  import ulactrl_pkg::*;
#(
  parameter int NSTATE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          Op,
  input  logic [5:0]          Funct,
  input  logic                Z,
  output logic [2:0]          ULAcontrol,
  output logic                ULASrcA,
  output logic [1:0]          ULASrcB,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic [1:0]          PCSrc,
  output logic                PCEn,
  output logic                Erro,
  output logic [NSTATE_W-1:0] Estado
);

  state_e     state_q, state_d;
  logic       erro_q, erro_d;

  logic [1:0] ula_op;
  logic       funct_illegal;
  logic       mem_write_raw, ir_write_raw, reg_write_raw;
  logic       pc_write, branch;

  ula_decoder u_ula_decoder (
    .ula_op_i        (ula_op),
    .funct_i         (Funct),
    .ula_control_o   (ULAcontrol),
    .funct_illegal_o (funct_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      erro_q  <= erro_d;
    end
  end

  // Flag is raised on the same edge that enters the trap state.
  assign erro_d = erro_q | (state_d == S_ERRO);

  always_comb begin
    state_d       = state_q;
    ula_op        = ULAOP_ADD;
    ULASrcA       = 1'b0;
    ULASrcB       = 2'b00;
    IorD          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    reg_write_raw = 1'b0;
    PCSrc         = 2'b00;
    pc_write      = 1'b0;
    branch        = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        ULASrcB      = 2'b01;
        pc_write     = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // Precompute branch target into ULAOut while the opcode is decoded.
        ULASrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ERRO;
        endcase
      end
      S_MEMADR: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
        state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECUTE: begin
        ULASrcA = 1'b1;
        ula_op  = ULAOP_FUNCT;
        state_d = funct_illegal ? S_ERRO : S_ULAWB;
      end
      S_ULAWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ULASrcA = 1'b1;
        ula_op  = ULAOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEXEC: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_ERRO:  state_d = S_ERRO;
      default: state_d = S_ERRO;
    endcase
  end

  // Enables are gated directly by rst_n so an asynchronous assertion kills
  // any in-flight write immediately, and FETCH's loads stay off in reset.
  assign MemWrite = mem_write_raw & rst_n;
  assign IRWrite  = ir_write_raw & rst_n;
  assign RegWrite = reg_write_raw & rst_n;
  assign PCEn     = (pc_write | (branch & Z)) & rst_n;
  assign Erro     = erro_q;
  assign Estado   = NSTATE_W'(state_q);

endmodule
